// File: rtl/motor_drive_control_if.sv
// Steering/travel command inputs and motor-driver pin outputs for motor_drive_control.
// The master drives the command; the slave (motor_drive_control) drives the pins.
interface motor_drive_control_if;
    logic [3:0] dir;
    logic       direction;
    logic       pwm_l;
    logic       pwm_r;
    logic       fwd_l;
    logic       fwd_r;
    logic [7:0] duty_l;
    logic [7:0] duty_r;
    logic       settled;

    modport master (
        output dir, direction,
        input  pwm_l, pwm_r, fwd_l, fwd_r, duty_l, duty_r, settled
    );

    modport slave (
        input  dir, direction,
        output pwm_l, pwm_r, fwd_l, fwd_r, duty_l, duty_r, settled
    );
endinterface

// File: rtl/motor_drive_control.sv
// Turns a 4-bit steering code plus travel direction into slew-limited per-wheel PWM,
// inserting a zero-duty dead gap before any H-bridge polarity change.
module motor_drive_control #(
    parameter int unsigned BASE_DUTY   = 200,
    parameter int unsigned VEER_DUTY   = 120,
    parameter int unsigned PIVOT_DUTY  = 160,
    parameter int unsigned RAMP_STEP   = 8,
    parameter int unsigned RAMP_DIV    = 1000,
    parameter int unsigned DEAD_CYCLES = 50000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    motor_drive_control_if.slave  bus
);
    localparam int unsigned PreW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned GapW = $clog2(DEAD_CYCLES + 1);
    localparam logic [7:0] BaseD  = BASE_DUTY[7:0];
    localparam logic [7:0] VeerD  = VEER_DUTY[7:0];
    localparam logic [7:0] PivotD = PIVOT_DUTY[7:0];
    localparam logic [7:0] StepD  = RAMP_STEP[7:0];
    localparam logic [3:0] DirStop = 4'b1111;

    typedef enum logic [1:0] {StStopped, StRun, StGap} state_e;

    state_e          r_state, w_state_nxt;
    logic [3:0]      r_dir;
    logic            r_trav;
    logic [7:0]      r_duty_l, r_duty_r, w_duty_l_nxt, w_duty_r_nxt;
    logic            r_fwd_l, r_fwd_r, w_fwd_l_nxt, w_fwd_r_nxt;
    logic [GapW-1:0] r_gap, w_gap_nxt;
    logic [PreW-1:0] r_pre;
    logic [7:0]      r_cnt;
    logic            r_pwm_l, r_pwm_r;
    logic [7:0]      w_tgt_l, w_tgt_r;
    logic            w_pol_l, w_pol_r, w_stop, w_tick;

    assign w_tick = (r_pre == PreW'(RAMP_DIV - 1));

    // Moves cur toward tgt by at most StepD without overshooting.
    function automatic logic [7:0] ramp(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] diff;
        if (cur < tgt) begin
            diff = tgt - cur;
            return cur + ((diff > StepD) ? StepD : diff);
        end
        diff = cur - tgt;
        return cur - ((diff > StepD) ? StepD : diff);
    endfunction

    always_comb begin
        w_tgt_l = 8'd0;
        w_tgt_r = 8'd0;
        w_pol_l = 1'b1;
        w_pol_r = 1'b1;
        w_stop  = 1'b0;
        case (r_dir)
            4'b0000: begin w_tgt_l = BaseD;  w_tgt_r = BaseD;  end
            4'b1001: begin w_tgt_l = BaseD;  w_tgt_r = VeerD;  end
            4'b1010: begin w_tgt_l = BaseD;  w_tgt_r = 8'd0;   end
            4'b1011: begin w_tgt_l = PivotD; w_tgt_r = PivotD; w_pol_r = 1'b0; end
            4'b0101: begin w_tgt_l = VeerD;  w_tgt_r = BaseD;  end
            4'b0110: begin w_tgt_l = 8'd0;   w_tgt_r = BaseD;  end
            4'b0111: begin w_tgt_l = PivotD; w_tgt_r = PivotD; w_pol_l = 1'b0; end
            default: w_stop = 1'b1;
        endcase
        if (!r_trav) begin
            w_pol_l = ~w_pol_l;
            w_pol_r = ~w_pol_r;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_duty_l_nxt = r_duty_l;
        w_duty_r_nxt = r_duty_r;
        w_fwd_l_nxt  = r_fwd_l;
        w_fwd_r_nxt  = r_fwd_r;
        w_gap_nxt    = r_gap;
        case (r_state)
            StStopped: begin
                w_duty_l_nxt = 8'd0;
                w_duty_r_nxt = 8'd0;
                if (!w_stop) begin
                    w_fwd_l_nxt = w_pol_l;
                    w_fwd_r_nxt = w_pol_r;
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (w_stop) begin
                    w_duty_l_nxt = 8'd0;
                    w_duty_r_nxt = 8'd0;
                    w_state_nxt  = StStopped;
                end else if ((w_pol_l != r_fwd_l) || (w_pol_r != r_fwd_r)) begin
                    w_duty_l_nxt = 8'd0;
                    w_duty_r_nxt = 8'd0;
                    w_gap_nxt    = GapW'(DEAD_CYCLES - 1);
                    w_state_nxt  = StGap;
                end else if (w_tick) begin
                    w_duty_l_nxt = ramp(r_duty_l, w_tgt_l);
                    w_duty_r_nxt = ramp(r_duty_r, w_tgt_r);
                end
            end
            StGap: begin
                w_duty_l_nxt = 8'd0;
                w_duty_r_nxt = 8'd0;
                if (w_stop) begin
                    w_state_nxt = StStopped;
                end else if (r_gap == '0) begin
                    w_fwd_l_nxt = w_pol_l;
                    w_fwd_r_nxt = w_pol_r;
                    w_state_nxt = StRun;
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            default: w_state_nxt = StStopped;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StStopped;
            r_dir    <= DirStop;
            r_trav   <= 1'b1;
            r_duty_l <= 8'd0;
            r_duty_r <= 8'd0;
            r_fwd_l  <= 1'b1;
            r_fwd_r  <= 1'b1;
            r_gap    <= '0;
            r_pre    <= '0;
            r_cnt    <= 8'd0;
            r_pwm_l  <= 1'b0;
            r_pwm_r  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dir    <= bus.dir;
            r_trav   <= bus.direction;
            r_duty_l <= w_duty_l_nxt;
            r_duty_r <= w_duty_r_nxt;
            r_fwd_l  <= w_fwd_l_nxt;
            r_fwd_r  <= w_fwd_r_nxt;
            r_gap    <= w_gap_nxt;
            r_pre    <= w_tick ? '0 : r_pre + 1'b1;
            r_cnt    <= r_cnt + 8'd1;
            r_pwm_l  <= (r_cnt < r_duty_l);
            r_pwm_r  <= (r_cnt < r_duty_r);
        end
    end

    assign bus.pwm_l   = r_pwm_l;
    assign bus.pwm_r   = r_pwm_r;
    assign bus.fwd_l   = r_fwd_l;
    assign bus.fwd_r   = r_fwd_r;
    assign bus.duty_l  = r_duty_l;
    assign bus.duty_r  = r_duty_r;
    assign bus.settled = (r_state == StRun) && (r_duty_l == w_tgt_l) && (r_duty_r == w_tgt_r);
endmodule

// File: tb/tb_motor_drive_control.sv
// Directed bench for motor_drive_control with short ramp and dead-gap parameters.
module tb_motor_drive_control;
    localparam logic [3:0] Proceed = 4'b0000;
    localparam logic [3:0] VeerR   = 4'b1001;
    localparam logic [3:0] NinetyR = 4'b1011;
    localparam logic [3:0] Stop    = 4'b1111;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    motor_drive_control_if bus ();

    motor_drive_control #(
        .BASE_DUTY  (200),
        .VEER_DUTY  (120),
        .PIVOT_DUTY (160),
        .RAMP_STEP  (8),
        .RAMP_DIV   (4),
        .DEAD_CYCLES(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_settled(input string tag, input int budget);
        int n = 0;
        while (bus.settled !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(bus.settled), 32'd1);
    endtask

    task automatic count_pwm(output int hi_l, output int hi_r);
        hi_l = 0;
        hi_r = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (bus.pwm_l === 1'b1) hi_l++;
            if (bus.pwm_r === 1'b1) hi_r++;
        end
    endtask

    initial begin
        int n;
        int hi_l, hi_r;

        // Reset state
        rst = 1'b1;
        bus.dir = Stop;
        bus.direction = 1'b1;
        step(3);
        chk("rst_pwm_l", 32'(bus.pwm_l), 0);
        chk("rst_fwd_l", 32'(bus.fwd_l), 1);
        chk("rst_fwd_r", 32'(bus.fwd_r), 1);
        chk("rst_duty_l", 32'(bus.duty_l), 0);
        chk("rst_settled", 32'(bus.settled), 0);

        // 1: ramp up under PROCEED, 8 per 4 cycles
        rst = 1'b0;
        bus.dir = Proceed;
        n = 0;
        while (bus.duty_l == 8'd0 && n < 20) begin
            step(1);
            n++;
        end
        chk("t1_first_l", 32'(bus.duty_l), 8);
        chk("t1_first_r", 32'(bus.duty_r), 8);
        for (int i = 2; i <= 25; i++) begin
            step(4);
            chk("t1_ramp_l", 32'(bus.duty_l), 32'(8 * i));
            chk("t1_ramp_r", 32'(bus.duty_r), 32'(8 * i));
        end
        chk("t1_settled", 32'(bus.settled), 1);

        // 2: PWM duty count, then VEER_RIGHT slews right wheel down
        count_pwm(hi_l, hi_r);
        chk("t2_pwm_l_hi", 32'(hi_l), 200);
        chk("t2_pwm_r_hi", 32'(hi_r), 200);
        bus.dir = VeerR;
        n = 0;
        while (bus.duty_r == 8'd200 && n < 20) begin
            step(1);
            n++;
        end
        chk("t2_veer_first", 32'(bus.duty_r), 192);
        for (int i = 1; i <= 9; i++) begin
            step(4);
            chk("t2_veer_r", 32'(bus.duty_r), 32'(192 - 8 * i));
        end
        chk("t2_veer_l", 32'(bus.duty_l), 200);
        chk("t2_settled", 32'(bus.settled), 1);

        // 3: pivot right needs a dead gap on the right bridge
        bus.dir = Proceed;
        wait_settled("t3_pre_settle", 100);
        bus.dir = NinetyR;
        step(1);
        chk("t3_reg_only", 32'(bus.duty_l), 200);
        step(1);
        chk("t3_gap_l0", 32'(bus.duty_l), 0);
        chk("t3_gap_r0", 32'(bus.duty_r), 0);
        step(15);
        chk("t3_gap_end_duty", 32'(bus.duty_r), 0);
        chk("t3_gap_end_fwd", 32'(bus.fwd_r), 1);
        step(1);
        chk("t3_fwd_r", 32'(bus.fwd_r), 0);
        chk("t3_fwd_l", 32'(bus.fwd_l), 1);
        chk("t3_run_duty0", 32'(bus.duty_l), 0);
        wait_settled("t3_settle", 200);
        chk("t3_pivot_l", 32'(bus.duty_l), 160);
        chk("t3_pivot_r", 32'(bus.duty_r), 160);

        // 4: reverse travel, then abort a gap with STOP
        bus.dir = Proceed;
        wait_settled("t4_pre_settle", 250);
        bus.direction = 1'b0;
        step(2);
        chk("t4_gap_l0", 32'(bus.duty_l), 0);
        step(15);
        chk("t4_gap_fwd_l", 32'(bus.fwd_l), 1);
        step(1);
        chk("t4_rev_fwd_l", 32'(bus.fwd_l), 0);
        chk("t4_rev_fwd_r", 32'(bus.fwd_r), 0);
        wait_settled("t4_rev_settle", 200);
        chk("t4_rev_duty", 32'(bus.duty_l), 200);
        bus.direction = 1'b1;
        step(2);
        chk("t4_gap2_r0", 32'(bus.duty_r), 0);
        step(5);
        bus.dir = Stop;
        step(2);
        chk("t4_stop_settled", 32'(bus.settled), 0);
        bus.direction = 1'b0;
        step(3);
        bus.direction = 1'b1;
        step(3);
        chk("t4_stop_hold_fwd", 32'(bus.fwd_l), 0);
        chk("t4_stop_hold_duty", 32'(bus.duty_l), 0);
        bus.dir = Proceed;
        step(2);
        chk("t4_restart_fwd_l", 32'(bus.fwd_l), 1);
        chk("t4_restart_fwd_r", 32'(bus.fwd_r), 1);
        wait_settled("t4_restart_settle", 200);

        // 5: undefined code stops the wheels two edges later
        bus.dir = 4'b0100;
        step(1);
        chk("t5_one_edge", 32'(bus.duty_l), 200);
        step(1);
        chk("t5_stop_l", 32'(bus.duty_l), 0);
        chk("t5_stop_r", 32'(bus.duty_r), 0);
        chk("t5_settled", 32'(bus.settled), 0);
        step(8);
        count_pwm(hi_l, hi_r);
        chk("t5_pwm_l_low", 32'(hi_l), 0);
        chk("t5_duty_hold", 32'(bus.duty_r), 0);

        // 6: reset during a gap, then during a ramp
        bus.dir = Proceed;
        bus.direction = 1'b0;
        wait_settled("t6_rev_settle", 200);
        chk("t6_rev_fwd", 32'(bus.fwd_l), 0);
        bus.direction = 1'b1;
        step(2);
        chk("t6_in_gap", 32'(bus.duty_l), 0);
        step(4);
        rst = 1'b1;
        step(1);
        chk("t6_gap_rst_fwd_l", 32'(bus.fwd_l), 1);
        chk("t6_gap_rst_fwd_r", 32'(bus.fwd_r), 1);
        chk("t6_gap_rst_duty", 32'(bus.duty_l), 0);
        chk("t6_gap_rst_settled", 32'(bus.settled), 0);
        rst = 1'b0;
        n = 0;
        while (bus.duty_l < 8'd40 && n < 100) begin
            step(1);
            n++;
        end
        chk("t6_mid_ramp", 32'(bus.duty_l >= 8'd40), 1);
        rst = 1'b1;
        step(1);
        chk("t6_ramp_rst_duty_l", 32'(bus.duty_l), 0);
        chk("t6_ramp_rst_duty_r", 32'(bus.duty_r), 0);
        chk("t6_ramp_rst_pwm_l", 32'(bus.pwm_l), 0);
        chk("t6_ramp_rst_pwm_r", 32'(bus.pwm_r), 0);
        chk("t6_ramp_rst_settled", 32'(bus.settled), 0);
        rst = 1'b0;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
